stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
- BCD stopwatch, MM:SS.hh, one stage downstream of the team's clock divider.
- Consumes the divider's 100 Hz divided clock as a count tick.
- Two active-low push buttons are debounced: start/stop and lap/clear.
- Drives 24 bits of packed BCD to the seven-segment decoders, plus status flags.

Parameters:
- DEBOUNCE_CYCLES, 500000, clk cycles a button must be stably pressed before one press event is produced (10 ms at 50 MHz).
- SYNC_STAGES, 2, synchronizer depth on tick_clk and on both buttons (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- tick_clk  in  1  divided clock from the divider; nominally 100 Hz, any duty cycle.
- btn_start_n  in  1  raw key, active-low, start/stop.
- btn_lap_n  in  1  raw key, active-low, lap/clear.
- display_bcd  out  24  {min_t,min_o,sec_t,sec_o,hun_t,hun_o}, 4 bits each.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP (display frozen).
- overflow  out  1  one-cycle pulse when the count wraps 59:59.99 -> 00:00.00.

Behaviour:
- Reset values:
  - display_bcd = 0, running = 0, lap_active = 0, overflow = 0.
  - FSM = IDLE, count = 0, debounce counters = 0.
  - tick synchronizer flops reset to 0; button synchronizer flops reset to 1.
- Tick detection:
  - tick_clk passes through SYNC_STAGES flops plus one history flop.
  - tick_pulse = synced & ~history.
  - The count register updates on the clk edge where tick_pulse is 1.
  - Latency: count changes on the (SYNC_STAGES+1)th clk edge after tick_clk is first sampled high. One increment per tick_clk rising edge.
- Debounce (sub-module button_debounce):
  - Synchronized input low -> counter increments; high -> counter clears to 0 and the press flag is re-armed.
  - When the counter reaches DEBOUNCE_CYCLES-1 while armed: emit a one-cycle press pulse, then disarm until release.
  - Holding the button produces exactly one pulse.
- Count:
  - hun_o 0-9, hun_t 0-9, sec_o 0-9, sec_t 0-5, min_o 0-9, min_t 0-5, ripple carry.
  - Increments only when tick_pulse is 1 and state is RUN or LAP.
  - Wrap at 59:59.99 -> 00:00.00, with overflow asserted the same cycle as the wrapped value.
- FSM states IDLE, RUN, PAUSE, LAP:
  - IDLE: start -> RUN.
  - RUN: start -> PAUSE; lap -> LAP (snapshot count into the lap register).
  - LAP: counting continues; start -> PAUSE; lap -> RUN.
  - PAUSE: start -> RUN; lap -> IDLE, clearing count to 0.
  - Other press/state combinations leave state unchanged.
- Simultaneous events:
  - start and lap pulses in the same cycle: start wins, lap is dropped.
  - A tick in the same cycle as a transition out of RUN/LAP is still counted (decision uses the current state).
- Display:
  - LAP shows the lap register.
  - All other states show the live count, registered.
  - display_bcd reflects a count change one cycle after the count register updates.
- Reset mid-operation: asynchronous clear of everything; no pending press or tick survives.

Decomposition:
- Shared package stopwatch_pkg holds:
  - enum state_t {IDLE, RUN, PAUSE, LAP};
  - typedef bcd_time_t, a packed struct of six 4-bit digits;
  - constants SEC_T_MAX=5, MIN_T_MAX=5.
- One sub-module: button_debounce (params DEBOUNCE_CYCLES, SYNC_STAGES; ports clk, reset, btn_n, press), instantiated twice.
- BCD increment is a function in the package.

Test Plan (DEBOUNCE_CYCLES=4; tick_clk toggles every 4 clk):
- Reset held low 10 cycles, buttons idle high, tick_clk running -> display_bcd=0x000000, running=0, lap_active=0, overflow never pulses.
- Start pressed 6 cycles, then 150 tick_clk rising edges -> display_bcd=0x000150, running=1; start again -> running=0; a further 20 ticks -> value stays 0x000150.
- Start, 50 ticks, lap press, 30 ticks -> display_bcd holds 0x000050 with lap_active=1; lap press -> display_bcd=0x000080, lap_active=0.
- Pause, then lap press -> IDLE, display_bcd=0x000000; start and lap pressed in the same cycle from IDLE -> RUN only, lap ignored.
- Run 360000 ticks from 0 -> display 0x595999 then 0x000000, overflow high exactly 1 cycle at the wrap.
- btn_start_n bounces low 3 cycles / high 1, repeated 5 times -> no press; held low 100 cycles -> exactly one state change.
- Reset asserted mid-RUN at 0x001234 -> outputs 0 in the same cycle; after release, counting only restarts after a new start press.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch.
//   state_t    : control FSM states (IDLE, RUN, PAUSE, LAP)
//   bcd_time_t : MM:SS.hh as six packed BCD digits, minutes-tens in the MSBs
//   bcd_inc    : ripple-carry increment of a bcd_time_t, wrapping 59:59.99 -> 00:00.00
//   bcd_is_max : true when a bcd_time_t holds 59:59.99
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] hun_t;
        logic [3:0] hun_o;
    } bcd_time_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] MIN_T_MAX = 4'd5;

    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r       = t;
        r.hun_o = t.hun_o + 4'd1;
        if (t.hun_o == DIGIT_MAX) begin
            r.hun_o = 4'd0;
            r.hun_t = t.hun_t + 4'd1;
            if (t.hun_t == DIGIT_MAX) begin
                r.hun_t = 4'd0;
                r.sec_o = t.sec_o + 4'd1;
                if (t.sec_o == DIGIT_MAX) begin
                    r.sec_o = 4'd0;
                    r.sec_t = t.sec_t + 4'd1;
                    if (t.sec_t == SEC_T_MAX) begin
                        r.sec_t = 4'd0;
                        r.min_o = t.min_o + 4'd1;
                        if (t.min_o == DIGIT_MAX) begin
                            r.min_o = 4'd0;
                            r.min_t = t.min_t + 4'd1;
                            if (t.min_t == MIN_T_MAX) begin
                                r.min_t = 4'd0;
                            end
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_is_max(input bcd_time_t t);
        return (t.min_t == MIN_T_MAX) && (t.min_o == DIGIT_MAX) &&
               (t.sec_t == SEC_T_MAX) && (t.sec_o == DIGIT_MAX) &&
               (t.hun_t == DIGIT_MAX) && (t.hun_o == DIGIT_MAX);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low push button.
// A single-cycle press pulse is produced once the synchronized button has
// been low for DEBOUNCE_CYCLES consecutive clk cycles; no further pulse is
// produced until the button has been seen released.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low
//   btn_n : raw button, active-low (asynchronous to clk)
//   press : one-cycle press event
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2     // must be >= 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   armed;

    // Synchronizer idles high (released) so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '1;
            cnt   <= '0;
            armed <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn_n};
            press <= 1'b0;
            if (sync[SYNC_STAGES-1]) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else if (cnt == CNT_MAX) begin
                // Counter parks here while held; armed limits it to one pulse.
                if (armed) begin
                    press <= 1'b1;
                    armed <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.hh BCD stopwatch counting rising edges of the 100 Hz divider clock.
// Ports:
//   clk         : system clock (50 MHz)
//   reset       : asynchronous, active-low; clears all state
//   tick_clk    : divided 100 Hz clock, any duty cycle, asynchronous to clk
//   btn_start_n : raw active-low start/stop key
//   btn_lap_n   : raw active-low lap/clear key
//   display_bcd : {min_t,min_o,sec_t,sec_o,hun_t,hun_o}, registered
//   running     : high in RUN and LAP
//   lap_active  : high in LAP (display frozen on the lap snapshot)
//   overflow    : one-cycle pulse when the count wraps to 00:00.00
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2     // must be >= 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_clk,
    input  logic        btn_start_n,
    input  logic        btn_lap_n,
    output logic [23:0] display_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    logic [SYNC_STAGES-1:0] tick_sync;
    logic                   tick_hist;
    logic                   tick_pulse;
    logic                   start_press;
    logic                   lap_press;
    logic                   counting;
    state_t                 state;
    bcd_time_t              count;
    bcd_time_t              lap_reg;
    bcd_time_t              display;

    // Tick edge detect: synchronizer followed by one history flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_sync <= '0;
            tick_hist <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_clk};
            tick_hist <= tick_sync[SYNC_STAGES-1];
        end
    end

    assign tick_pulse = tick_sync[SYNC_STAGES-1] & ~tick_hist;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_start (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_start_n),
        .press (start_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_lap (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_lap_n),
        .press (lap_press)
    );

    // Counting is decided on the current state, so a tick coinciding with
    // a transition out of RUN/LAP is still counted.
    assign counting = tick_pulse && ((state == RUN) || (state == LAP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            lap_reg  <= '0;
            display  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= counting && bcd_is_max(count);
            if (counting) begin
                count <= bcd_inc(count);
            end
            display <= (state == LAP) ? lap_reg : count;

            // Start has priority; a lap press in the same cycle is dropped.
            if (start_press) begin
                case (state)
                    IDLE:     state <= RUN;
                    RUN, LAP: state <= PAUSE;
                    PAUSE:    state <= RUN;
                    default:  state <= IDLE;
                endcase
            end else if (lap_press) begin
                case (state)
                    RUN: begin
                        state   <= LAP;
                        lap_reg <= count;
                    end
                    LAP:   state <= RUN;
                    PAUSE: begin
                        // No tick is counted in PAUSE, so the clear cannot race it.
                        state <= IDLE;
                        count <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign display_bcd = display;
    assign running     = (state == RUN) || (state == LAP);
    assign lap_active  = (state == LAP);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd. The reference model keeps elapsed time
// as an integer number of hundredths and converts to BCD with div/mod; every
// change of the expected display is queued and a monitor pops one entry each
// time the DUT's display changes.
module tb_stopwatch_bcd;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_clk;
    logic        btn_start_n;
    logic        btn_lap_n;
    logic [23:0] display_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    always #5 clk = ~clk;

    stopwatch_bcd #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_clk    (tick_clk),
        .btn_start_n (btn_start_n),
        .btn_lap_n   (btn_lap_n),
        .display_bcd (display_bcd),
        .running     (running),
        .lap_active  (lap_active),
        .overflow    (overflow)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic [23:0] last_pushed = 24'h0;
    logic [23:0] last_seen   = 24'h0;

    int cs         = 0;
    int lap_cs     = 0;
    int mstate     = M_IDLE;
    int exp_wraps  = 0;
    int ovf_cycles = 0;
    bit ovf_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        int m, s, h;
        m = v / 6000;
        s = (v / 100) % 60;
        h = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    task automatic model_push();
        logic [23:0] e;
        e = to_bcd((mstate == M_LAP) ? lap_cs : cs);
        if (e != last_pushed) begin
            exp_q.push_back(e);
            last_pushed = e;
        end
    endtask

    task automatic model_event(input bit s, input bit l);
        if (s) begin
            if (mstate == M_IDLE || mstate == M_PAUSE) mstate = M_RUN;
            else                                      mstate = M_PAUSE;
        end else if (l) begin
            if (mstate == M_RUN) begin
                mstate = M_LAP;
                lap_cs = cs;
            end else if (mstate == M_LAP) begin
                mstate = M_RUN;
            end else if (mstate == M_PAUSE) begin
                mstate = M_IDLE;
                cs     = 0;
            end
        end
        model_push();
    endtask

    task automatic ticks(input int n, input int half);
        repeat (n) begin
            @(negedge clk);
            tick_clk = 1'b1;
            if (mstate == M_RUN || mstate == M_LAP) begin
                cs++;
                if (cs == 360000) begin
                    cs = 0;
                    exp_wraps++;
                end
                model_push();
            end
            repeat (half) @(negedge clk);
            tick_clk = 1'b0;
            repeat (half - 1) @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit l, input int hold);
        @(negedge clk);
        if (s) btn_start_n = 1'b0;
        if (l) btn_lap_n   = 1'b0;
        model_event(s, l);
        repeat (hold) @(negedge clk);
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_flags(input string name);
        check({name, "_running"}, 32'(running), 32'((mstate == M_RUN) || (mstate == M_LAP)));
        check({name, "_lap_active"}, 32'(lap_active), 32'(mstate == M_LAP));
    endtask

    // Monitor: one scoreboard pop per observed display change; overflow tracking.
    always @(negedge clk) begin
        if (display_bcd !== last_seen) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL display_unexpected: got %h, want no change from %h", display_bcd, last_seen);
            end else begin
                check("display_seq", 32'(display_bcd), 32'(exp_q.pop_front()));
            end
            last_seen = display_bcd;
        end
        if (ovf_pending) check("display_after_wrap", 32'(display_bcd), 32'h0);
        ovf_pending = (overflow === 1'b1);
        if (overflow === 1'b1) ovf_cycles++;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL timeout: got no finish, want finish before 100000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        tick_clk    = 1'b0;
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;

        // Reset held with tick_clk running.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i % 4 == 0) tick_clk = ~tick_clk;
        end
        check("reset_display", 32'(display_bcd), 32'h0);
        check_flags("reset");
        check("reset_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        reset    = 1'b1;
        tick_clk = 1'b0;
        repeat (8) @(negedge clk);
        check_flags("idle");

        // Run 150 ticks, pause, further ticks ignored.
        press(1'b1, 1'b0, 6);
        check_flags("run");
        ticks(150, 4);
        drain("t150");
        check("disp_150", 32'(display_bcd), 32'h000150);
        press(1'b1, 1'b0, 6);
        check_flags("pause");
        ticks(20, 4);
        drain("pause20");
        check("disp_paused", 32'(display_bcd), 32'h000150);

        // Clear from PAUSE, then lap sequence.
        press(1'b0, 1'b1, 6);
        drain("clear");
        check("disp_clear", 32'(display_bcd), 32'h0);
        press(1'b1, 1'b0, 6);
        ticks(50, 4);
        press(1'b0, 1'b1, 6);
        ticks(30, 4);
        drain("lap");
        check("disp_lap", 32'(display_bcd), 32'h000050);
        check_flags("lap");
        press(1'b0, 1'b1, 6);
        drain("unlap");
        check("disp_unlap", 32'(display_bcd), 32'h000080);
        check_flags("unlap");

        // Pause, clear, then simultaneous presses from IDLE.
        press(1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 6);
        drain("clear2");
        check("disp_clear2", 32'(display_bcd), 32'h0);
        press(1'b1, 1'b1, 6);
        check_flags("both");
        ticks(7, 3);
        drain("both_ticks");

        // Randomized operation mix.
        repeat (40) begin
            case ($urandom_range(0, 4))
                0, 1:    ticks(int'($urandom_range(1, 25)), int'($urandom_range(2, 5)));
                2:       press(1'b1, 1'b0, int'($urandom_range(6, 12)));
                3:       press(1'b0, 1'b1, int'($urandom_range(6, 12)));
                default: press(1'b1, 1'b1, int'($urandom_range(6, 12)));
            endcase
            drain("rand");
            check_flags("rand");
        end

        // Wrap: preset the paused count just below 59:59.99.
        while (mstate != M_PAUSE) press(1'b1, 1'b0, 6);
        @(negedge clk);
        force dut.count = 24'h595990;
        cs = 359990;
        model_push();
        repeat (3) @(negedge clk);
        release dut.count;
        drain("preset");
        check("disp_preset", 32'(display_bcd), 32'h595990);
        press(1'b1, 1'b0, 6);
        ticks(15, 2);
        drain("wrap");
        check("disp_wrapped", 32'(display_bcd), 32'h000005);
        check("wrap_overflow", 32'(ovf_cycles), 32'(exp_wraps));

        // Bouncing start key must not register; long hold registers once.
        repeat (5) begin
            @(negedge clk);
            btn_start_n = 1'b0;
            repeat (3) @(negedge clk);
            btn_start_n = 1'b1;
        end
        repeat (8) @(negedge clk);
        check_flags("bounce");
        @(negedge clk);
        btn_start_n = 1'b0;
        model_event(1'b1, 1'b0);
        repeat (100) @(negedge clk);
        btn_start_n = 1'b1;
        repeat (8) @(negedge clk);
        check_flags("hold");
        ticks(10, 4);
        drain("hold");
        check("disp_hold", 32'(display_bcd), 32'h000005);

        // Reset mid-RUN at 00:12.34.
        @(negedge clk);
        force dut.count = 24'h001234;
        cs = 1234;
        model_push();
        repeat (3) @(negedge clk);
        release dut.count;
        drain("preset2");
        press(1'b1, 1'b0, 6);
        check_flags("run2");
        @(posedge clk);
        #3;
        mstate = M_IDLE;
        cs     = 0;
        model_push();
        reset = 1'b0;
        #1;
        check("rst_display", 32'(display_bcd), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_lap_active", 32'(lap_active), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ticks(10, 4);
        drain("post_reset");
        check("disp_post_reset", 32'(display_bcd), 32'h0);
        check_flags("post_reset");
        press(1'b1, 1'b0, 6);
        ticks(5, 4);
        drain("restart");
        check("disp_restart", 32'(display_bcd), 32'h000005);

        check("overflow_pulses", 32'(ovf_cycles), 32'(exp_wraps));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
